// File: rtl/cdc_pulse_feeder_if.sv
// Source-domain signal bundle between an event producer, the pulse feeder and
// the handshake pulse synchronizer.
interface cdc_pulse_feeder_if #(
   parameter int CNT_W = 8
);
   logic             s_event_in;
   logic             s_busy;
   logic             s_clr_err;
   logic             s_pulse_out;
   logic [CNT_W-1:0] s_pending;
   logic             s_overflow;
   logic             s_timeout_err;

   modport master (
      input  s_event_in,
      input  s_busy,
      input  s_clr_err,
      output s_pulse_out,
      output s_pending,
      output s_overflow,
      output s_timeout_err
   );

   modport slave (
      output s_event_in,
      output s_busy,
      output s_clr_err,
      input  s_pulse_out,
      input  s_pending,
      input  s_overflow,
      input  s_timeout_err
   );
endinterface

// File: rtl/cdc_pulse_feeder.sv
// Queues incoming event pulses and feeds them one at a time to the handshake
// pulse synchronizer, only while it reports not-busy.
module cdc_pulse_feeder #(
   parameter int CNT_W  = 8,
   parameter int TO_CYC = 64
) (
   input  logic                s_clk,
   input  logic                s_rst,
   cdc_pulse_feeder_if.master  bus
);

   localparam int               TO_W    = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TO_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_HI,
      WAIT_LO
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [TO_W-1:0]  to_cnt;
   logic             pulse_r;
   logic             ovf_r;
   logic             to_r;

   logic             inc;
   logic             dec;
   logic             ovf_set;
   logic             to_hit;

   assign inc     = bus.s_event_in;
   assign dec     = (state == IDLE) && (count != '0) && !bus.s_busy;
   assign ovf_set = inc && !dec && (count == CNT_MAX);
   assign to_hit  = (TO_CYC != 0) && (state == WAIT_HI) && !bus.s_busy &&
                    (to_cnt == TO_LAST);

   // A timed-out issue is not re-queued; the event counts as delivered.
   always_ff @(posedge s_clk) begin
      if (s_rst) begin
         state   <= IDLE;
         count   <= '0;
         to_cnt  <= '0;
         pulse_r <= 1'b0;
         ovf_r   <= 1'b0;
         to_r    <= 1'b0;
      end else begin
         pulse_r <= 1'b0;
         case (state)
            IDLE: begin
               if (dec) begin
                  state   <= ISSUE;
                  pulse_r <= 1'b1;
               end
            end
            ISSUE: begin
               state  <= WAIT_HI;
               to_cnt <= '0;
            end
            WAIT_HI: begin
               if (bus.s_busy) begin
                  state <= WAIT_LO;
               end else if (to_hit) begin
                  state <= IDLE;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            WAIT_LO: begin
               if (!bus.s_busy) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (inc && !dec) begin
            if (count != CNT_MAX) begin
               count <= count + CNT_W'(1);
            end
         end else if (dec && !inc) begin
            count <= count - CNT_W'(1);
         end

         // A fresh set condition outranks a same-cycle clear.
         if (ovf_set) begin
            ovf_r <= 1'b1;
         end else if (bus.s_clr_err) begin
            ovf_r <= 1'b0;
         end

         if (to_hit) begin
            to_r <= 1'b1;
         end else if (bus.s_clr_err) begin
            to_r <= 1'b0;
         end
      end
   end

   assign bus.s_pulse_out   = pulse_r;
   assign bus.s_pending     = count;
   assign bus.s_overflow    = ovf_r;
   assign bus.s_timeout_err = to_r;

endmodule
